// File: rtl/pmem_arb_pkg.sv
// rtl/pmem_arb_pkg.sv - shared types and default widths for the physical-memory arbiter
package pmem_arb_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} requester_t;

endpackage

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin sharing of one line-wide pmem port between I-cache and D-cache
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state;
  requester_t last_grant;
  logic       i_req;
  logic       d_req;
  logic       serve_i;
  logic       serve_d;

  assign i_req   = i_pmem_read;
  assign d_req   = d_pmem_read | d_pmem_write;
  assign serve_i = (state == SERVE_I);
  assign serve_d = (state == SERVE_D);

  // On a tie the requester that did not win last time gets the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_I;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && (!d_req || last_grant == REQ_D)) begin
            state      <= SERVE_I;
            last_grant <= REQ_I;
          end else if (d_req) begin
            state      <= SERVE_D;
            last_grant <= REQ_D;
          end
        end
        SERVE_I: if (pmem_resp) state <= DONE;
        SERVE_D: if (pmem_resp) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pmem_read    = serve_i | (serve_d & d_pmem_read & ~d_pmem_write);
    pmem_write   = serve_d & d_pmem_write;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (serve_i) begin
      pmem_address = i_pmem_address;
    end else if (serve_d) begin
      pmem_address = d_pmem_address;
      pmem_wdata   = d_pmem_wdata;
    end
  end

  // Responses reach only the granted cache; stray pmem_resp elsewhere is dropped.
  always_comb begin
    i_pmem_resp  = serve_i & pmem_resp;
    d_pmem_resp  = serve_d & pmem_resp;
    i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
    d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;
  end

  a_d_read_write_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_pmem_read && d_pmem_write));

  a_i_held_while_served: assert property (@(posedge clk) disable iff (!rst_n)
    (state == SERVE_I) |-> i_pmem_read);

  a_d_held_while_served: assert property (@(posedge clk) disable iff (!rst_n)
    (state == SERVE_D) |-> (d_pmem_read || d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - scoreboard bench for pmem_arbiter with a behavioural line memory
module tb_pmem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int LAT    = 5;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [LINE_W-1:0] wdata;
  } cmd_t;

  logic              clk;
  logic              rst_n;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;

  cmd_t              cmd_q[$];
  logic [LINE_W-1:0] i_exp_q[$];
  logic [LINE_W-1:0] d_exp_q[$];
  logic [LINE_W-1:0] mem [logic [ADDR_W-1:0]];

  localparam logic [LINE_W-1:0] PAT_A5   = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_DEAD = {8{32'hDEADBEEF}};

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] fill_of(input logic [ADDR_W-1:0] a);
    return {8{a}};
  endfunction

  // Memory: answers LAT cycles after a command appears; abandons on reset.
  initial begin
    int cnt;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n || pmem_resp) begin
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == LAT) begin
          pmem_resp = 1'b1;
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : fill_of(pmem_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: command order, command hold, response routing, DONE/IDLE gap.
  initial begin
    logic              prev_cmd;
    logic [ADDR_W-1:0] cur_addr;
    int                gap;
    cmd_t              c;
    prev_cmd = 1'b0;
    cur_addr = '0;
    gap      = 0;
    forever begin
      @(negedge clk);
      if (gap > 0) begin
        check("gap_cmd", {pmem_read, pmem_write}, 0);
        gap--;
      end
      if ((pmem_read || pmem_write) && !prev_cmd) begin
        if (cmd_q.size() > 0) begin
          c = cmd_q.pop_front();
          check("cmd_addr", pmem_address, c.addr);
          check("cmd_write", pmem_write, c.wr);
          check("cmd_read", pmem_read, !c.wr);
          check("cmd_wdata", pmem_wdata, c.wr ? c.wdata : '0);
        end else begin
          check("cmd_unexpected", cmd_q.size(), 1);
        end
        cur_addr = pmem_address;
      end else if (pmem_read || pmem_write) begin
        check("cmd_hold", pmem_address, cur_addr);
      end
      prev_cmd = pmem_read | pmem_write;
      if (i_pmem_resp) begin
        i_resp_cnt++;
        gap = 2;
        check("i_excl", {d_pmem_resp, d_pmem_rdata}, 0);
        if (i_exp_q.size() > 0) check("i_rdata", i_pmem_rdata, i_exp_q.pop_front());
        else check("i_resp_unexpected", i_exp_q.size(), 1);
      end
      if (d_pmem_resp) begin
        d_resp_cnt++;
        gap = 2;
        check("d_excl", {i_pmem_resp, i_pmem_rdata}, 0);
        if (d_exp_q.size() > 0) check("d_rdata", d_pmem_rdata, d_exp_q.pop_front());
        else check("d_resp_unexpected", d_exp_q.size(), 1);
      end
    end
  end

  task automatic i_xfer(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] exp);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    i_pmem_address = a;
    i_pmem_read    = 1'b1;
    i_exp_q.push_back(exp);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = i_pmem_resp;
    end
    check("i_resp_seen", seen, 1);
    @(posedge clk); #1;
    i_pmem_read = 1'b0;
  endtask

  task automatic d_xfer(input logic [ADDR_W-1:0] a, input logic wr, input logic [LINE_W-1:0] wd,
                        input logic [LINE_W-1:0] exp);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    d_pmem_address = a;
    d_pmem_wdata   = wd;
    d_pmem_read    = !wr;
    d_pmem_write   = wr;
    d_exp_q.push_back(exp);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = d_pmem_resp;
    end
    check("d_resp_seen", seen, 1);
    @(posedge clk); #1;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int d_before;
    rst_n          = 1'b0;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;

    repeat (3) begin
      @(negedge clk);
      check("rst_cmd", {pmem_read, pmem_write, pmem_address, i_pmem_resp, d_pmem_resp}, 0);
      check("rst_data", pmem_wdata | i_pmem_rdata | d_pmem_rdata, 0);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;

    repeat (20) begin
      @(negedge clk);
      check("idle_quiet", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, 0);
    end

    // Lone I-cache read of a preloaded line.
    mem[32'h100] = PAT_A5;
    cmd_q.push_back('{32'h100, 1'b0, '0});
    i_xfer(32'h100, PAT_A5);
    repeat (3) @(negedge clk);
    check("lone_i_icnt", i_resp_cnt, 1);
    check("lone_i_dcnt", d_resp_cnt, 0);

    // D-cache writeback then readback.
    cmd_q.push_back('{32'h1FE0, 1'b1, PAT_DEAD});
    d_xfer(32'h1FE0, 1'b1, PAT_DEAD, '0);
    cmd_q.push_back('{32'h1FE0, 1'b0, '0});
    d_xfer(32'h1FE0, 1'b0, '0, PAT_DEAD);
    repeat (3) @(negedge clk);
    check("wb_dcnt", d_resp_cnt, 2);
    check("wb_icnt", i_resp_cnt, 1);

    // Tie right after reset: D first.
    do_reset();
    cmd_q.push_back('{32'h80, 1'b0, '0});
    cmd_q.push_back('{32'h40, 1'b0, '0});
    fork
      i_xfer(32'h40, fill_of(32'h40));
      d_xfer(32'h80, 1'b0, '0, fill_of(32'h80));
    join
    repeat (3) @(negedge clk);
    check("tie_cmd_q_empty", cmd_q.size(), 0);

    // Continuous contention: strict D, I alternation.
    for (int k = 0; k < 5; k++) begin
      cmd_q.push_back('{32'h1000 + k * 32'h20, 1'b0, '0});
      cmd_q.push_back('{32'h2000 + k * 32'h20, 1'b0, '0});
    end
    fork
      for (int k = 0; k < 5; k++) i_xfer(32'h2000 + k * 32'h20, fill_of(32'h2000 + k * 32'h20));
      for (int k = 0; k < 5; k++) d_xfer(32'h1000 + k * 32'h20, 1'b0, '0, fill_of(32'h1000 + k * 32'h20));
    join
    repeat (3) @(negedge clk);
    check("rr_icnt", i_resp_cnt, 7);
    check("rr_dcnt", d_resp_cnt, 8);

    // Reset two cycles into SERVE_D: command abandoned, grant history cleared.
    d_before = d_resp_cnt;
    cmd_q.push_back('{32'h300, 1'b0, '0});
    @(posedge clk); #1;
    d_pmem_address = 32'h300;
    d_pmem_read    = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n       = 1'b0;
    d_pmem_read = 1'b0;
    #1;
    check("midrst_cmd", {pmem_read, pmem_write, pmem_address}, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_no_dresp", d_resp_cnt, d_before);

    cmd_q.push_back('{32'h380, 1'b0, '0});
    cmd_q.push_back('{32'h200, 1'b0, '0});
    fork
      i_xfer(32'h200, fill_of(32'h200));
      d_xfer(32'h380, 1'b0, '0, fill_of(32'h380));
    join
    repeat (4) @(negedge clk);
    check("post_rst_dcnt", d_resp_cnt, d_before + 1);
    check("end_cmd_q", cmd_q.size(), 0);
    check("end_i_q", i_exp_q.size(), 0);
    check("end_d_q", d_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
